multicycle_control_unit: RTL and testbench

Parametrised multi-cycle control unit for the ARM-subset processor. It sequences each instruction through a state machine and drives one shared datapath (single memory, single ALU), so one instruction completes over several cycles. It owns the condition-flag register and condition evaluation, and adds EOR, CMN and TST. An optional multi-cycle MUL path is enabled by parameter.

---
 rtl/multicycle_control_unit.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the ARM-subset processor: sequences each
// instruction through a Moore FSM over a shared memory/ALU datapath, owns the
// NZCV flag register and condition evaluation, and optionally runs a
// multi-cycle MUL.
module multicycle_control_unit #(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MulStart,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_MULEX    = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  localparam bit         MUL_EN   = (MUL_CYCLES > 0);
  localparam logic [3:0] MUL_LOAD = 4'((MUL_CYCLES > 0) ? (MUL_CYCLES - 1) : 0);

  state_t     state, next;
  logic [3:0] flags;      // {N,Z,C,V}
  logic [3:0] mul_cnt;
  logic       from_mul;   // ALUWB reached from MULEX selects the multiplier result

  logic [1:0] op;
  logic [3:0] cmd, cond, rd;
  logic       ibit, sbit, ubit, is_mul, condex;
  logic       dp_ok, nowrite, arith;
  logic [2:0] dp_op, aluop;
  logic       pcw, irw, rw, mw;

  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

  assign op     = Instr[27:26];
  assign ibit   = Instr[25];
  assign cmd    = Instr[24:21];
  assign sbit   = Instr[20];
  assign ubit   = Instr[23];
  assign rd     = Instr[15:12];
  assign cond   = Instr[31:28];
  assign is_mul = (op == 2'b00) && (Instr[25:24] == 2'b00) && (Instr[7:4] == 4'b1001);

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = !cy;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = cy && !z;
      4'b1001: cond_eval = !cy || z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = !z && (n == v);
      4'b1101: cond_eval = z || (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign condex = cond_eval(cond, flags);

  // Data-processing cmd decode: ALU op, compare-only, and full-vs-NZ flag class
  always_comb begin
    dp_ok   = 1'b0;
    dp_op   = ALU_ADD;
    nowrite = 1'b0;
    arith   = 1'b0;
    case (cmd)
      4'b0100: begin dp_ok = 1'b1; dp_op = ALU_ADD; arith = 1'b1; end
      4'b0010: begin dp_ok = 1'b1; dp_op = ALU_SUB; arith = 1'b1; end
      4'b0000: begin dp_ok = 1'b1; dp_op = ALU_AND; end
      4'b1100: begin dp_ok = 1'b1; dp_op = ALU_ORR; end
      4'b0001: begin dp_ok = (ALUCTRL_W >= 3); dp_op = ALU_EOR; end
      4'b1010: begin dp_ok = 1'b1; dp_op = ALU_SUB; nowrite = 1'b1; arith = 1'b1; end
      4'b1011: begin dp_ok = 1'b1; dp_op = ALU_ADD; nowrite = 1'b1; arith = 1'b1; end
      4'b1000: begin dp_ok = 1'b1; dp_op = ALU_AND; nowrite = 1'b1; end
      default: ;
    endcase
  end

  // State, flag, and MUL counter registers; reset aborts any instruction in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_FETCH;
      flags    <= 4'b0000;
      mul_cnt  <= 4'd0;
      from_mul <= 1'b0;
    end else begin
      state    <= next;
      from_mul <= (state == S_MULEX);
      if (state == S_DECODE && next == S_MULEX)
        mul_cnt <= MUL_LOAD;
      else if (state == S_MULEX && mul_cnt != 4'd0)
        mul_cnt <= mul_cnt - 4'd1;
      if ((state == S_EXECR || state == S_EXECI) && condex && (sbit || nowrite)) begin
        if (arith) flags <= ALUFlags;
        else       flags[3:2] <= ALUFlags[3:2];
      end
    end
  end

  // Next-state and Moore outputs; enables are gated by reset afterwards
  always_comb begin
    next      = S_FETCH;
    pcw       = 1'b0;
    irw       = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    aluop     = ALU_ADD;
    case (state)
      S_FETCH: begin
        irw = 1'b1; pcw = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        if (!condex)                next = S_FETCH;
        else if (op == 2'b01)       next = S_MEMADR;
        else if (op == 2'b10)       next = S_BRANCH;
        else if (op == 2'b11)       next = S_FETCH;
        else if (is_mul)            next = MUL_EN ? S_MULEX : S_FETCH;
        else if (!dp_ok)            next = S_FETCH;
        else if (ibit)              next = S_EXECI;
        else                        next = S_EXECR;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        aluop   = ubit ? ALU_ADD : ALU_SUB;
        next    = sbit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        next   = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01; rw = 1'b1; pcw = (rd == 4'd15);
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; mw = 1'b1;
        next   = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (state == S_EXECI) ? 2'b01 : 2'b00;
        aluop   = dp_op;
        next    = nowrite ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = from_mul ? 2'b11 : 2'b00;
        rw = 1'b1; pcw = (rd == 4'd15);
        next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; pcw = 1'b1;
        next    = S_FETCH;
      end
      S_MULEX: begin
        next = (mul_cnt == 4'd0) ? S_ALUWB : S_MULEX;
      end
      default: next = S_FETCH;
    endcase
  end

  assign PCWrite    = pcw & ~RESET;
  assign IRWrite    = irw & ~RESET;
  assign RegWrite   = rw & ~RESET;
  assign MemWrite   = mw & ~RESET;
  assign MulStart   = (state == S_MULEX) && (mul_cnt == MUL_LOAD) && !RESET;
  assign ALUControl = ALUCTRL_W'(aluop);
  assign State      = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a full-featured instance
// (EOR + 3-cycle MUL) checked cycle by cycle from a queue of expected output
// vectors, plus a 2-bit-ALUControl instance that must treat EORS as unsupported.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'hE5110004;
  logic [31:0] instr2 = 32'hE0321003;
  logic [3:0]  aluflags = 4'b0000;

  logic       pcw, irw, rw, mw, adr, asa, ms;
  logic [1:0] asb, rs, imm, rsrc;
  logic [2:0] aluc;
  logic [3:0] st;

  logic       pcw2, irw2, rw2, mw2, adr2, asa2, ms2;
  logic [1:0] asb2, rs2, imm2, rsrc2, aluc2;
  logic [3:0] st2;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUCTRL_W(3), .MUL_CYCLES(3)) dut (
    .CLK(clk), .RESET(rst), .Instr(instr), .ALUFlags(aluflags),
    .PCWrite(pcw), .IRWrite(irw), .RegWrite(rw), .MemWrite(mw),
    .AdrSrc(adr), .ALUSrcA(asa), .ALUSrcB(asb), .ResultSrc(rs),
    .ImmSrc(imm), .RegSrc(rsrc), .ALUControl(aluc), .MulStart(ms), .State(st)
  );

  multicycle_control_unit #(.ALUCTRL_W(2), .MUL_CYCLES(0)) dut2 (
    .CLK(clk), .RESET(rst), .Instr(instr2), .ALUFlags(aluflags),
    .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rw2), .MemWrite(mw2),
    .AdrSrc(adr2), .ALUSrcA(asa2), .ALUSrcB(asb2), .ResultSrc(rs2),
    .ImmSrc(imm2), .RegSrc(rsrc2), .ALUControl(aluc2), .MulStart(ms2), .State(st2)
  );

  // Observed vector: {State, PCW, IRW, RW, MW, MulStart, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc}
  logic [21:0] obs1;
  assign obs1 = {st, pcw, irw, rw, mw, ms, adr, asa, asb, rs, aluc, imm, rsrc};

  // The narrow instance runs EORS forever, so it must just alternate FETCH/DECODE.
  logic ph2;
  always_ff @(posedge clk or posedge rst)
    if (rst) ph2 <= 1'b0;
    else     ph2 <= ~ph2;

  logic [7:0] obs2;
  assign obs2 = {st2, pcw2, irw2, rw2, mw2};

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [21:0] v(input logic [3:0] s, input logic [4:0] en,
                                    input logic a, input logic sa,
                                    input logic [1:0] sb, input logic [1:0] r,
                                    input logic [2:0] alu, input logic [3:0] sel);
    return {s, en, a, sa, sb, r, alu, sel};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input logic [21:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_fd(input string tag, input logic [3:0] sel);
    push({tag, ".fetch"},  v(4'd0, 5'b11000, 1'b0, 1'b1, 2'b10, 2'b10, 3'd0, sel));
    push({tag, ".decode"}, v(4'd1, 5'b00000, 1'b0, 1'b1, 2'b10, 2'b10, 3'd0, sel));
  endtask

  task automatic run_q();
    logic [21:0] e;
    logic [7:0]  e2;
    string       t;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      e2 = {ph2 ? 4'd1 : 4'd0, ~ph2 & ~rst, ~ph2 & ~rst, 1'b0, 1'b0};
      check(t, 32'(obs1), 32'(e));
      check({t, ".w2"}, 32'(obs2), 32'(e2));
      @(posedge clk); #1;
    end
  endtask

  task automatic branch(input string tag, input logic [31:0] ins, input logic taken);
    instr = ins;
    push_fd(tag, 4'b1001);
    if (taken) push({tag, ".branch"}, v(4'd9, 5'b10000, 1'b0, 1'b0, 2'b01, 2'b10, 3'd0, 4'b1001));
    run_q();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: FETCH decode with all enables forced low
    push("reset", v(4'd0, 5'b00000, 1'b0, 1'b1, 2'b10, 2'b10, 3'd0, 4'b0110));
    run_q();
    rst = 1'b0;

    // LDR R0,[R1,#-4] interrupted by reset in MEMREAD
    instr = 32'hE5110004;
    push_fd("ldr_abort", 4'b0110);
    push("ldr_abort.memadr", v(4'd2, 5'b00000, 1'b0, 1'b0, 2'b01, 2'b00, 3'd1, 4'b0110));
    run_q();
    check("ldr_abort.in_memread", 32'(st), 32'd3);
    #2 rst = 1'b1;
    push("reset_mid", v(4'd0, 5'b00000, 1'b0, 1'b1, 2'b10, 2'b10, 3'd0, 4'b0110));
    run_q();
    rst = 1'b0;

    // Same LDR completes normally afterwards
    push_fd("ldr", 4'b0110);
    push("ldr.memadr",  v(4'd2, 5'b00000, 1'b0, 1'b0, 2'b01, 2'b00, 3'd1, 4'b0110));
    push("ldr.memread", v(4'd3, 5'b00000, 1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0110));
    push("ldr.memwb",   v(4'd4, 5'b00100, 1'b0, 1'b0, 2'b00, 2'b01, 3'd0, 4'b0110));
    run_q();

    // Flags are 0000 after reset: BEQ not taken
    branch("beq_after_reset", 32'h0A000002, 1'b0);

    // LDR PC: PCWrite in MEMWB
    instr = 32'hE511F004;
    push_fd("ldr_pc", 4'b0110);
    push("ldr_pc.memadr",  v(4'd2, 5'b00000, 1'b0, 1'b0, 2'b01, 2'b00, 3'd1, 4'b0110));
    push("ldr_pc.memread", v(4'd3, 5'b00000, 1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0110));
    push("ldr_pc.memwb",   v(4'd4, 5'b10100, 1'b0, 1'b0, 2'b00, 2'b01, 3'd0, 4'b0110));
    run_q();

    // STR with U=0
    instr = 32'hE5010004;
    push_fd("str", 4'b0110);
    push("str.memadr",   v(4'd2, 5'b00000, 1'b0, 1'b0, 2'b01, 2'b00, 3'd1, 4'b0110));
    push("str.memwrite", v(4'd5, 5'b00010, 1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0110));
    run_q();

    // SUBS R1,R2,R3 with Z from ALU, then BEQ taken
    instr = 32'hE0521003; aluflags = 4'b0100;
    push_fd("subs", 4'b0000);
    push("subs.exec",  v(4'd6, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1, 4'b0000));
    push("subs.aluwb", v(4'd8, 5'b00100, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0000));
    run_q();
    aluflags = 4'b0000;
    branch("beq_taken", 32'h0A000002, 1'b1);

    // CMP with Z=1, then BNE not taken
    instr = 32'hE1520003; aluflags = 4'b0100;
    push_fd("cmp", 4'b0000);
    push("cmp.exec", v(4'd6, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd1, 4'b0000));
    run_q();
    aluflags = 4'b0000;
    branch("bne_not_taken", 32'h1A000002, 1'b0);

    // ADDS R1,R2,#1 sets C and V
    instr = 32'hE2921001; aluflags = 4'b0011;
    push_fd("adds", 4'b0000);
    push("adds.exec",  v(4'd7, 5'b00000, 1'b0, 1'b0, 2'b01, 2'b00, 3'd0, 4'b0000));
    push("adds.aluwb", v(4'd8, 5'b00100, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0000));
    run_q();

    // EORS: only N,Z change; C,V must survive although ALU reports 0
    instr = 32'hE0321003; aluflags = 4'b1000;
    push_fd("eors", 4'b0000);
    push("eors.exec",  v(4'd6, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd4, 4'b0000));
    push("eors.aluwb", v(4'd8, 5'b00100, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0000));
    run_q();
    aluflags = 4'b0000;
    branch("bcs_kept_c", 32'h2A000002, 1'b1);
    branch("bvs_kept_v", 32'h6A000002, 1'b1);
    branch("bmi_new_n",  32'h4A000002, 1'b1);
    branch("beq_new_z",  32'h0A000002, 1'b0);
    branch("cond_never", 32'hFA000002, 1'b0);

    // Unsupported cmd (MOV) is dropped after DECODE
    instr = 32'hE1A01002;
    push_fd("unsupported", 4'b0000);
    run_q();

    // CMN producing 0000 flags, then BNE taken
    instr = 32'hE1720003; aluflags = 4'b0000;
    push_fd("cmn", 4'b0000);
    push("cmn.exec", v(4'd6, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0000));
    run_q();
    branch("bne_taken", 32'h1A000002, 1'b1);

    // MUL with 3 execute cycles, MulStart only on the first
    instr = 32'hE0000291;
    push_fd("mul", 4'b0000);
    push("mul.mulex1", v(4'd10, 5'b00001, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0000));
    push("mul.mulex2", v(4'd10, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0000));
    push("mul.mulex3", v(4'd10, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd0, 4'b0000));
    push("mul.aluwb",  v(4'd8,  5'b00100, 1'b0, 1'b0, 2'b00, 2'b11, 3'd0, 4'b0000));
    push("mul.next_fetch", v(4'd0, 5'b11000, 1'b0, 1'b1, 2'b10, 2'b10, 3'd0, 4'b0000));
    run_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
